// File: rtl/fp32_mac_pkg.sv
// Shared types and FP32 constants for the sequential FP32 multiply-accumulate block.
package fp32_mac_pkg;

    typedef enum logic [1:0] {IDLE, SETTLE, OUT} mac_state_t;

    localparam int          FP32_W    = 32;
    localparam logic [31:0] FP32_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP32_ONE  = 32'h3F80_0000;
    localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;

endpackage

// File: rtl/fp32_mul_add_comb.sv
// Purely combinational FP32 y = a*b + c: multiply and add each round to nearest-even.
// Subnormal inputs and results flush to zero.
module fp32_mul_add_comb
    import fp32_mac_pkg::*;
(
    input  logic [FP32_W-1:0] a,
    input  logic [FP32_W-1:0] b,
    input  logic [FP32_W-1:0] c,
    output logic [FP32_W-1:0] y
);

    function automatic logic [31:0] fp_mul(input logic [31:0] x, input logic [31:0] z);
        logic               s;
        logic [7:0]         ex, ez;
        logic [47:0]        p;
        logic [23:0]        mm;
        logic [24:0]        m;
        logic               g, st;
        logic signed [9:0]  e;
        logic [31:0]        r;
        s  = x[31] ^ z[31];
        ex = x[30:23];
        ez = z[30:23];
        p  = {24'd0, 1'b1, x[22:0]} * {24'd0, 1'b1, z[22:0]};
        e  = $signed({2'b00, ex}) + $signed({2'b00, ez}) - 10'sd127;
        if (p[47]) begin
            mm = p[47:24]; g = p[23]; st = |p[22:0]; e = e + 10'sd1;
        end else begin
            mm = p[46:23]; g = p[22]; st = |p[21:0];
        end
        m = {1'b0, mm} + {24'd0, g & (st | mm[0])};
        if (m[24]) begin
            m = m >> 1; e = e + 10'sd1;
        end
        if ((ex == 8'hFF && x[22:0] != 23'd0) || (ez == 8'hFF && z[22:0] != 23'd0) ||
            (ex == 8'hFF && ez == 8'd0) || (ez == 8'hFF && ex == 8'd0))
            r = FP32_QNAN;
        else if (ex == 8'hFF || ez == 8'hFF || e >= 10'sd255)
            r = {s, 8'hFF, 23'd0};
        else if (ex == 8'd0 || ez == 8'd0 || e <= 10'sd0)
            r = {s, 31'd0};
        else
            r = {s, e[7:0], m[22:0]};
        return r;
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] u, input logic [31:0] v);
        logic [31:0]        x, z, r;
        logic [7:0]         d;
        logic [26:0]        mx, mz;
        logic [27:0]        sum;
        logic [24:0]        rnd;
        logic signed [9:0]  e;
        if (u[30:0] >= v[30:0]) begin x = u; z = v; end
        else                    begin x = v; z = u; end
        d  = x[30:23] - z[30:23];
        mx = {1'b1, x[22:0], 3'b000};
        mz = {1'b1, z[22:0], 3'b000};
        // Three extra low bits (guard, round, sticky) survive the alignment shift.
        if (d > 8'd26) mz = 27'd1;
        else           mz = (mz >> d) | {26'd0, |(mz & ((27'd1 << d) - 27'd1))};
        e = $signed({2'b00, x[30:23]});
        if (x[31] == z[31]) sum = {1'b0, mx} + {1'b0, mz};
        else                sum = {1'b0, mx} - {1'b0, mz};
        if (sum[27]) begin
            sum = {1'b0, sum[27:2], sum[1] | sum[0]};
            e   = e + 10'sd1;
        end
        for (int i = 0; i < 27; i++) begin
            if (sum != 28'd0 && !sum[26]) begin
                sum = sum << 1;
                e   = e - 10'sd1;
            end
        end
        rnd = {1'b0, sum[26:3]} + {24'd0, sum[2] & (sum[1] | sum[0] | sum[3])};
        if (rnd[24]) begin
            rnd = rnd >> 1; e = e + 10'sd1;
        end
        if ((u[30:23] == 8'hFF && u[22:0] != 23'd0) || (v[30:23] == 8'hFF && v[22:0] != 23'd0) ||
            (u[30:23] == 8'hFF && v[30:23] == 8'hFF && u[31] != v[31]))
            r = FP32_QNAN;
        else if (u[30:23] == 8'hFF) r = u;
        else if (v[30:23] == 8'hFF) r = v;
        else if (v[30:23] == 8'd0)  r = (u[30:23] == 8'd0) ? {u[31] & v[31], 31'd0} : u;
        else if (u[30:23] == 8'd0)  r = v;
        else if (sum == 28'd0)      r = FP32_ZERO;
        else if (e >= 10'sd255)     r = {x[31], 8'hFF, 23'd0};
        else if (e <= 10'sd0)       r = {x[31], 31'd0};
        else                        r = {x[31], e[7:0], rnd[22:0]};
        return r;
    endfunction

    assign y = fp_add(fp_mul(a, b), c);

endmodule

// File: rtl/fp32_mac_seq_acc.sv
// Sequential FP32 MAC: accumulates N_TERMS products onto a bias with valid/ready handshakes.
// Define FP32_MAC_DEBUG_EN to replace the result with a bring-up result counter.
module fp32_mac_seq_acc
    import fp32_mac_pkg::*;
#(
    parameter int N_TERMS       = 4,
    parameter int SETTLE_CYCLES = 4,
    parameter int TERM_W        = $clog2(N_TERMS + 1),
    parameter int SET_W         = $clog2(SETTLE_CYCLES + 1)
) (
    input  logic              CLK_I,
    input  logic              RSTL_I,
    input  logic              CLEAR_I,
    input  logic [FP32_W-1:0] ALPHA_I,
    input  logic [FP32_W-1:0] BRAVO_I,
    input  logic [FP32_W-1:0] ACC_INIT_I,
    input  logic              IN_VALID_I,
    output logic              IN_READY_O,
    output logic [FP32_W-1:0] DELTA_O,
    output logic              OUT_VALID_O,
    input  logic              OUT_READY_I,
    output logic [TERM_W-1:0] TERM_IDX_O,
    output logic              BUSY_O
);

    localparam logic [SET_W-1:0]  SET_LAST  = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [TERM_W-1:0] TERM_LAST = TERM_W'(N_TERMS - 1);

    mac_state_t        state;
    logic [FP32_W-1:0] alpha_p0, bravo_p0, acc_op_p0;
    logic [FP32_W-1:0] acc_reg;
    logic [FP32_W-1:0] mac_res;
    logic [SET_W-1:0]  set_cnt;
`ifdef FP32_MAC_DEBUG_EN
    logic [FP32_W-1:0] res_cnt;
`endif

    fp32_mul_add_comb u_mul_add (
        .a (alpha_p0),
        .b (bravo_p0),
        .c (acc_op_p0),
        .y (mac_res)
    );

    assign BUSY_O = (state != IDLE);

    always_ff @(posedge CLK_I or negedge RSTL_I) begin
        if (!RSTL_I) begin
            state       <= IDLE;
            IN_READY_O  <= 1'b0;
            OUT_VALID_O <= 1'b0;
            DELTA_O     <= FP32_ZERO;
            TERM_IDX_O  <= '0;
            alpha_p0    <= FP32_ZERO;
            bravo_p0    <= FP32_ZERO;
            acc_op_p0   <= FP32_ZERO;
            acc_reg     <= FP32_ZERO;
            set_cnt     <= '0;
`ifdef FP32_MAC_DEBUG_EN
            res_cnt     <= '0;
`endif
        end else if (CLEAR_I) begin
            // Abort: DELTA_O and the debug counter deliberately keep their values.
            state       <= IDLE;
            IN_READY_O  <= 1'b1;
            OUT_VALID_O <= 1'b0;
            TERM_IDX_O  <= '0;
            acc_reg     <= FP32_ZERO;
            set_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (IN_VALID_I && IN_READY_O) begin
                        alpha_p0   <= ALPHA_I;
                        bravo_p0   <= BRAVO_I;
                        acc_op_p0  <= (TERM_IDX_O == '0) ? ACC_INIT_I : acc_reg;
                        set_cnt    <= '0;
                        IN_READY_O <= 1'b0;
                        state      <= SETTLE;
                    end else begin
                        IN_READY_O <= 1'b1;
                    end
                end
                SETTLE: begin
                    set_cnt <= set_cnt + SET_W'(1);
                    if (set_cnt == SET_LAST) begin
                        acc_reg <= mac_res;
                        if (TERM_IDX_O == TERM_LAST) begin
`ifdef FP32_MAC_DEBUG_EN
                            res_cnt <= res_cnt + 32'd1;
                            DELTA_O <= res_cnt + 32'd1;
`else
                            DELTA_O <= mac_res;
`endif
                            TERM_IDX_O  <= '0;
                            OUT_VALID_O <= 1'b1;
                            state       <= OUT;
                        end else begin
                            TERM_IDX_O <= TERM_IDX_O + TERM_W'(1);
                            IN_READY_O <= 1'b1;
                            state      <= IDLE;
                        end
                    end
                end
                OUT: begin
                    if (OUT_READY_I) begin
                        OUT_VALID_O <= 1'b0;
                        IN_READY_O  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp32_mac_seq_acc.sv
// Directed bench for fp32_mac_seq_acc; expectations switch when FP32_MAC_DEBUG_EN is defined.
module tb_fp32_mac_seq_acc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        clear = 1'b0;
    logic [31:0] alpha = '0, bravo = '0, acc_init = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] delta;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [2:0]  term_idx;
    logic        busy;

    int checks = 0;
    int failures = 0;

`ifdef FP32_MAC_DEBUG_EN
    localparam logic [31:0] EXP_BIAS  = 32'd1;
    localparam logic [31:0] EXP_RST   = 32'd1;
    localparam logic [31:0] EXP_CLR   = 32'd2;
    localparam logic [31:0] EXP_FINAL = 32'd3;
`else
    localparam logic [31:0] EXP_BIAS  = 32'h4110_0000;  // 1 + 4*(2*1) = 9.0
    localparam logic [31:0] EXP_RST   = 32'h4100_0000;  // 0 + 4*(1*2) = 8.0
    localparam logic [31:0] EXP_CLR   = 32'h4080_0000;  // 0 + 4*(0.5*2) = 4.0
    localparam logic [31:0] EXP_FINAL = 32'h3F80_0000;  // 13 + 4*(3*-1) = 1.0
`endif

    fp32_mac_seq_acc dut (
        .CLK_I       (clk),
        .RSTL_I      (rst_n),
        .CLEAR_I     (clear),
        .ALPHA_I     (alpha),
        .BRAVO_I     (bravo),
        .ACC_INIT_I  (acc_init),
        .IN_VALID_I  (in_valid),
        .IN_READY_O  (in_ready),
        .DELTA_O     (delta),
        .OUT_VALID_O (out_valid),
        .OUT_READY_I (out_ready),
        .TERM_IDX_O  (term_idx),
        .BUSY_O      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] init);
        int n = 0;
        alpha = a; bravo = b; acc_init = init; in_valid = 1'b1;
        while (!in_ready && n < 40) begin tick(); n++; end
        check("send_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out();
        int n = 0;
        while (!out_valid && n < 60) begin tick(); n++; end
        check("wait_out_valid", 32'(out_valid), 32'd1);
    endtask

    initial begin
        int acc_pos [4];
        int n_acc = 0;
        int first_out = -1;
        int bad = 0;
        int n_out = 0;
        logic [31:0] cap = '0;
        logic [31:0] held;

        // Reset values and the one-cycle ready delay after release
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_delta", delta, 32'd0);
        check("rst_term_idx", 32'(term_idx), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        check("first_cycle_ready_low", 32'(in_ready), 32'd0);
        tick();
        check("ready_after_first_cycle", 32'(in_ready), 32'd1);

        // Bias accumulation with IN_VALID held high: acceptance cadence and output latency
        alpha = 32'h4000_0000; bravo = 32'h3F80_0000; acc_init = 32'h3F80_0000;
        in_valid = 1'b1;
        for (int i = 0; i < 21; i++) begin
            if (in_ready) begin
                if (n_acc < 4) acc_pos[n_acc] = i;
                n_acc++;
            end
            if (out_valid && first_out < 0) first_out = i;
            tick();
        end
        check("accept_count", 32'(n_acc), 32'd4);
        check("accept0_pos", 32'(acc_pos[0]), 32'd0);
        check("accept1_pos", 32'(acc_pos[1]), 32'd5);
        check("accept2_pos", 32'(acc_pos[2]), 32'd10);
        check("accept3_pos", 32'(acc_pos[3]), 32'd15);
        check("out_valid_latency", 32'(first_out), 32'd20);
        check("bias_result", delta, EXP_BIAS);

        // Back-pressure: 10 cycles with OUT_READY low
        for (int k = 0; k < 10; k++) begin
            if (delta !== EXP_BIAS || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
            tick();
        end
        check("backpressure_violations", 32'(bad), 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("out_valid_dropped", 32'(out_valid), 32'd0);
        check("ready_after_out", 32'(in_ready), 32'd1);
        tick();
        check("next_term_accepted", 32'(busy), 32'd1);

        // Run into the third term of the next accumulation, then reset in SETTLE
        repeat (10) tick();
        in_valid = 1'b0;
        check("mid_accum_busy", 32'(busy), 32'd1);
        check("mid_accum_term_idx", 32'(term_idx), 32'd2);
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_term_idx", 32'(term_idx), 32'd0);
        check("async_rst_delta", delta, 32'd0);
        check("async_rst_in_ready", 32'(in_ready), 32'd0);
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int t = 0; t < 4; t++) send(32'h3F80_0000, 32'h4000_0000, 32'h0000_0000);
        for (int k = 0; k < 12; k++) begin
            if (out_valid) begin n_out++; cap = delta; end
            tick();
        end
        check("post_rst_out_valid_count", 32'(n_out), 32'd1);
        check("post_rst_result", cap, EXP_RST);
        out_ready = 1'b0;

        // CLEAR after 2 of 4 terms, with a concurrent IN_VALID that must not be taken
        held = delta;
        send(32'h4000_0000, 32'h4000_0000, 32'h3F80_0000);
        send(32'h4000_0000, 32'h4000_0000, 32'h3F80_0000);
        for (int k = 0; k < 10 && !in_ready; k++) tick();
        check("pre_clear_term_idx", 32'(term_idx), 32'd2);
        in_valid = 1'b1;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        in_valid = 1'b0;
        check("clear_term_idx", 32'(term_idx), 32'd0);
        check("clear_not_busy", 32'(busy), 32'd0);
        check("clear_out_valid", 32'(out_valid), 32'd0);
        check("clear_delta_kept", delta, held);
        for (int t = 0; t < 4; t++) send(32'h3F00_0000, 32'h4000_0000, 32'h0000_0000);
        wait_out();
        check("post_clear_result", delta, EXP_CLR);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Cancelling accumulation with negative products
        for (int t = 0; t < 4; t++) send(32'h4040_0000, 32'hBF80_0000, 32'h4150_0000);
        wait_out();
        check("final_result", delta, EXP_FINAL);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp32_mac_seq_acc.md
Name: fp32_mac_seq_acc

Overview:
- Parametrised successor of the single-shot FP32 MAC.
- Accumulates N_TERMS FP32 products, alpha[i]*bravo[i], onto an initial bias, then presents one FP32 result.
- Uses level valid/ready handshakes on input and output. No edge detection.
- Sits between the UART RX deserialiser and the TX serialiser. The multi-cycle settle window covers the long combinational multiply/add path.

Parameters:
- N_TERMS, 4, products accumulated per result; must be >=1.
- SETTLE_CYCLES, 4, cycles operands are held stable before the adder output is latched; must be >=1.
- TERM_W, $clog2(N_TERMS+1), width of the term counter.
- SET_W, $clog2(SETTLE_CYCLES+1), width of the settle counter.

Ports:
- CLK_I  in  1  clock, rising edge.
- RSTL_I  in  1  asynchronous active-low reset.
- CLEAR_I  in  1  synchronous abort of the current accumulation.
- ALPHA_I  in  32  FP32 multiplicand.
- BRAVO_I  in  32  FP32 multiplier.
- ACC_INIT_I  in  32  FP32 bias; sampled only with term 0.
- IN_VALID_I  in  1  operand pair valid.
- IN_READY_O  out  1  block can accept an operand pair.
- DELTA_O  out  32  FP32 result.
- OUT_VALID_O  out  1  DELTA_O valid.
- OUT_READY_I  in  1  downstream accepts the result.
- TERM_IDX_O  out  TERM_W  index of the next term expected.
- BUSY_O  out  1  high when state != IDLE.

Behaviour:
- Reset: RSTL_I low asynchronously forces the following, abandoning any in-flight accumulation:
  - state=IDLE
  - IN_READY_O=0 for the first cycle after deassertion, then 1
  - OUT_VALID_O=0, DELTA_O=0, TERM_IDX_O=0, BUSY_O=0
  - internal operand, accumulator and counter registers = 0
- States: IDLE, SETTLE, OUT.
- IDLE:
  - IN_READY_O=1.
  - On IN_VALID_I&&IN_READY_O:
    - register ALPHA_I and BRAVO_I;
    - accumulator operand := ACC_INIT_I if term_idx==0, else acc_reg;
    - settle counter := 0; go to SETTLE.
- SETTLE:
  - IN_READY_O=0; registered operands held constant.
  - Settle counter increments each cycle.
  - On the cycle the counter reaches SETTLE_CYCLES-1:
    - acc_reg := mul_add result;
    - if term_idx==N_TERMS-1: DELTA_O := result, term_idx := 0, go to OUT;
    - else term_idx+1, go to IDLE.
- OUT:
  - OUT_VALID_O=1; DELTA_O stable; IN_READY_O=0.
  - On OUT_READY_I: OUT_VALID_O drops next cycle, go to IDLE.
- Latency and throughput:
  - Input handshake to latch of that term = SETTLE_CYCLES+1 cycles.
  - Throughput = 1 term per SETTLE_CYCLES+1 cycles.
- Accumulator path is FP32. The result is exactly what the mul/add chain produces; no extra rounding or saturation.
- CLEAR_I:
  - Highest priority after reset, from any state.
  - Next state IDLE, term_idx=0, OUT_VALID_O=0, acc_reg=0.
  - A concurrent IN_VALID_I is not accepted that cycle.
  - DELTA_O keeps its last value.
- Boundary cases:
  - N_TERMS==1: every accepted pair produces a result.
  - OUT_READY_I held high in OUT: the result is consumed in its first valid cycle.
  - IN_VALID_I high during SETTLE or OUT: ignored (not consumed); upstream holds it.
  - term_idx wraps to 0 only through the OUT transition or CLEAR_I.

Optional Feature:
- Macro: FP32_MAC_DEBUG_EN.
- Defined:
  - the arithmetic result is replaced by a 32-bit result counter: first result=1, +1 per OUT entry;
  - handshakes and timing are unchanged;
  - the counter resets to 0 on RSTL_I only, not on CLEAR_I;
  - used for link bring-up.
- Undefined: the true FP32 accumulation is used and no counter exists.

Decomposition:
- Package fp32_mac_pkg holds:
  - the mac_state_t enum {IDLE, SETTLE, OUT};
  - FP32_W=32;
  - FP32_ZERO=32'h0000_0000;
  - FP32_ONE=32'h3F80_0000.
- Sub-module fp32_mul_add_comb: pure combinational a*b+c, instantiating the existing combinational FP32 multiplier and adder. The top level owns all registers and the FSM.

Test Plan:
- Reset while in SETTLE mid-accumulation:
  - all outputs reach reset values immediately;
  - after release, the accumulation 4×(1.0×2.0)+0.0 yields DELTA_O=0x41000000 with exactly one OUT_VALID_O.
- Accumulate with bias:
  - N_TERMS=4, ACC_INIT_I=0x3F800000, four pairs (0x40000000, 0x3F800000);
  - DELTA_O=0x41100000 (9.0).
- Handshake timing:
  - SETTLE_CYCLES=4, IN_VALID_I held high continuously;
  - IN_READY_O pulses once per 5 cycles;
  - OUT_VALID_O asserts 20 cycles after the first acceptance.
- Output back-pressure:
  - OUT_READY_I low for 10 cycles;
  - DELTA_O stable, IN_READY_O=0 throughout; the next term is accepted 1 cycle after the OUT handshake.
- CLEAR_I after 2 of 4 terms:
  - TERM_IDX_O→0;
  - the next 4 terms 0.5×2.0 with bias 0 give 0x40800000 (4.0).
- FP32_MAC_DEBUG_EN defined, three full accumulations:
  - DELTA_O=1, 2, 3;
  - the counter survives CLEAR_I.
